sap_datapath: RTL and testbench

//  Receiving end of the 12-bit control word issued by the SAP-style sequencer.

---
 rtl/sap_datapath_if.sv | 68 ++++++
 rtl/sap_datapath.sv | 160 ++++++++++++++++
 tb/tb_sap_datapath.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_datapath_if.sv
// ----------------------------------------------------------------------------
// sap_datapath_if
// Purpose : groups the sequencer-facing control word, the program-load port and
//           the status/observation outputs of the SAP datapath into one bundle.
// Signals :
//   ctrl[11:0]    {hlt,pc_inc,pc_en,mar_load,mem_en,ir_load,ir_en,
//                  a_load,a_en,b_load,adder_sub,adder_en}
//   opcode[3:0]   IR high nibble returned to the sequencer
//   prog_we       program-load write strobe
//   prog_addr     program-load address
//   prog_data     program-load data
//   halted        sticky halt flag
//   a_out         accumulator A
//   pc_out        program counter
//   bus_out       current bus value (combinational)
//   carry, zero   adder flags
//   bus_conflict  more than one bus driver enabled (combinational)
// Modports:
//   master : sequencer / program loader side
//   slave  : datapath side
// ----------------------------------------------------------------------------
interface sap_datapath_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic [11:0]       ctrl;
    logic [3:0]        opcode;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              halted;
    logic [DATA_W-1:0] a_out;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] bus_out;
    logic              carry;
    logic              zero;
    logic              bus_conflict;

    modport master (
        output ctrl,
        output prog_we,
        output prog_addr,
        output prog_data,
        input  opcode,
        input  halted,
        input  a_out,
        input  pc_out,
        input  bus_out,
        input  carry,
        input  zero,
        input  bus_conflict
    );

    modport slave (
        input  ctrl,
        input  prog_we,
        input  prog_addr,
        input  prog_data,
        output opcode,
        output halted,
        output a_out,
        output pc_out,
        output bus_out,
        output carry,
        output zero,
        output bus_conflict
    );
endinterface

// File: rtl/sap_datapath.sv
// ----------------------------------------------------------------------------
// sap_datapath
// Purpose : receiving end of the SAP sequencer's 12-bit control word. Holds PC,
//           MAR, program RAM, IR, A, B, the add/sub unit and the shared bus and
//           executes one micro-step per rising clk. The sequencer itself steps
//           on the falling edge, so ctrl is stable around every rising edge.
// Ports   :
//   clk     rising-edge clock for all state
//   rst     asynchronous, active-high reset (RAM is not reset)
//   io_sap  slave side of sap_datapath_if (ctrl, program load, status outputs)
// ----------------------------------------------------------------------------
module sap_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    sap_datapath_if.slave  io_sap
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // Control word decode
    // ------------------------------------------------------------------
    logic w_hlt;
    logic w_pc_inc;
    logic w_pc_en;
    logic w_mar_load;
    logic w_mem_en;
    logic w_ir_load;
    logic w_ir_en;
    logic w_a_load;
    logic w_a_en;
    logic w_b_load;
    logic w_adder_sub;
    logic w_adder_en;

    assign {w_hlt, w_pc_inc, w_pc_en, w_mar_load, w_mem_en, w_ir_load,
            w_ir_en, w_a_load, w_a_en, w_b_load, w_adder_sub, w_adder_en} = io_sap.ctrl;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_ram [Depth];
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_carry;
    logic              r_zero;
    logic              r_halted;

    // ------------------------------------------------------------------
    // Add/sub unit: subtraction is a + ~b + 1, so carry=1 means no borrow
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_b_operand;
    logic [DATA_W:0]   w_sum_ext;
    logic [DATA_W-1:0] w_sum;
    logic              w_adder_c;

    assign w_b_operand = w_adder_sub ? ~r_b : r_b;
    assign w_sum_ext   = {1'b0, r_a} + {1'b0, w_b_operand} + {{DATA_W{1'b0}}, w_adder_sub};
    assign w_sum       = w_sum_ext[DATA_W-1:0];
    assign w_adder_c   = w_sum_ext[DATA_W];

    // ------------------------------------------------------------------
    // Shared bus
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_ram_rd;
    logic [DATA_W-1:0] w_bus;
    logic [2:0]        w_num_en;

    assign w_ram_rd = r_ram[r_mar];

    // Fixed priority keeps the bus well defined even when the sequencer
    // enables several drivers; the conflict flag reports it separately.
    always_comb begin
        w_bus = '0;
        if (w_pc_en) begin
            w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
        end else if (w_mem_en) begin
            w_bus = w_ram_rd;
        end else if (w_ir_en) begin
            w_bus = {{(DATA_W-4){1'b0}}, r_ir[3:0]};
        end else if (w_a_en) begin
            w_bus = r_a;
        end else if (w_adder_en) begin
            w_bus = w_sum;
        end
    end

    assign w_num_en = 3'(w_pc_en) + 3'(w_mem_en) + 3'(w_ir_en) + 3'(w_a_en) + 3'(w_adder_en);

    // ------------------------------------------------------------------
    // Program RAM: written only by the external loader, never by the
    // datapath, and independent of reset and halt.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (io_sap.prog_we) begin
            r_ram[io_sap.prog_addr] <= io_sap.prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Register file. All loads sample the same pre-edge bus value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_mar    <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            if (!r_halted) begin
                if (w_mar_load) begin
                    r_mar <= w_bus[ADDR_W-1:0];
                end
                if (w_ir_load) begin
                    r_ir <= w_bus;
                end
                if (w_a_load) begin
                    r_a <= w_bus;
                end
                if (w_b_load) begin
                    r_b <= w_bus;
                end
                if (w_pc_inc) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
                // Flags track the adder whenever a result lands in A with the
                // adder enabled, even if a higher-priority driver owns the bus.
                if (w_a_load && w_adder_en) begin
                    r_carry <= w_adder_c;
                    r_zero  <= (w_sum == '0);
                end
            end
            if (w_hlt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_sap.opcode       = r_ir[DATA_W-1 -: 4];
    assign io_sap.halted       = r_halted;
    assign io_sap.a_out        = r_a;
    assign io_sap.pc_out       = r_pc;
    assign io_sap.bus_out      = w_bus;
    assign io_sap.carry        = r_carry;
    assign io_sap.zero         = r_zero;
    assign io_sap.bus_conflict = (w_num_en > 3'd1);

endmodule

// File: tb/tb_sap_datapath.sv
// ----------------------------------------------------------------------------
// tb_sap_datapath
// Self-checking bench for sap_datapath: vector table, hand-written sequences
// (PC wrap, full program run, asynchronous reset mid-instruction) and a
// randomized phase compared against a behavioural model.
// ----------------------------------------------------------------------------
module tb_sap_datapath;
    localparam int HLT = 11, PC_INC = 10, PC_EN = 9, MAR_LOAD = 8, MEM_EN = 7, IR_LOAD = 6;
    localparam int IR_EN = 5, A_LOAD = 4, A_EN = 3, B_LOAD = 2, ADDER_SUB = 1, ADDER_EN = 0;

    localparam logic [11:0] C_HLT = 12'h800, C_PC_INC = 12'h400, C_PC_EN = 12'h200;
    localparam logic [11:0] C_MAR_LOAD = 12'h100, C_MEM_EN = 12'h080, C_IR_LOAD = 12'h040;
    localparam logic [11:0] C_IR_EN = 12'h020, C_A_LOAD = 12'h010, C_A_EN = 12'h008;
    localparam logic [11:0] C_B_LOAD = 12'h004, C_SUB = 12'h002, C_ADD_EN = 12'h001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sap_datapath_if #(.DATA_W(8), .ADDR_W(4)) u_if ();

    sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_sap (u_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    logic [7:0] m_ram [16];
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b;
    logic       m_c, m_z, m_h;

    function automatic int m_add_total(input logic sub);
        if (sub) return int'(m_a) + (255 - int'(m_b)) + 1;
        return int'(m_a) + int'(m_b);
    endfunction

    function automatic logic [7:0] m_bus(input logic [11:0] c);
        if (c[PC_EN])    return {4'h0, m_pc};
        if (c[MEM_EN])   return m_ram[m_mar];
        if (c[IR_EN])    return {4'h0, m_ir[3:0]};
        if (c[A_EN])     return m_a;
        if (c[ADDER_EN]) return 8'(m_add_total(c[ADDER_SUB]) % 256);
        return 8'h00;
    endfunction

    function automatic int n_en(input logic [11:0] c);
        return int'(c[PC_EN]) + int'(c[MEM_EN]) + int'(c[IR_EN]) + int'(c[A_EN])
             + int'(c[ADDER_EN]);
    endfunction

    task automatic m_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_h = 0;
    endtask

    task automatic m_edge(input logic [11:0] c, input logic pw, input logic [3:0] pa,
                          input logic [7:0] pd);
        logic [7:0] bus;
        int tot;
        bus = m_bus(c);
        tot = m_add_total(c[ADDER_SUB]);
        if (!m_h) begin
            if (c[MAR_LOAD]) m_mar = bus[3:0];
            if (c[IR_LOAD])  m_ir = bus;
            if (c[A_LOAD])   m_a = bus;
            if (c[B_LOAD])   m_b = bus;
            if (c[PC_INC])   m_pc = 4'((int'(m_pc) + 1) % 16);
            if (c[A_LOAD] && c[ADDER_EN]) begin
                m_c = (tot > 255);
                m_z = ((tot % 256) == 0);
            end
        end
        if (c[HLT]) m_h = 1'b1;
        if (pw) m_ram[pa] = pd;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic apply_reset(input bit with_prog);
        logic [3:0] pa [7];
        logic [7:0] pd [7];
        pa = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hB};
        pd = '{8'h09, 8'h1A, 8'h2B, 8'hF0, 8'h1C, 8'h0E, 8'h04};
        @(negedge clk);
        rst = 1'b1;
        u_if.ctrl = '0;
        u_if.prog_we = 1'b0;
        if (with_prog) begin
            for (int i = 0; i < 7; i++) begin
                u_if.prog_we = 1'b1;
                u_if.prog_addr = pa[i];
                u_if.prog_data = pd[i];
                @(negedge clk);
            end
            u_if.prog_we = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic tick(input logic [11:0] c);
        @(negedge clk);
        u_if.ctrl = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] seq_ctrl(input int t, input logic [3:0] op);
        if (t == 1) return C_PC_EN | C_MAR_LOAD;
        if (t == 2) return C_PC_INC;
        if (t == 3) return C_MEM_EN | C_IR_LOAD;
        if (t == 4) return (op == 4'hF) ? C_HLT : (C_IR_EN | C_MAR_LOAD);
        if (t == 5) begin
            if (op == 4'h0) return C_MEM_EN | C_A_LOAD;
            if (op == 4'h1 || op == 4'h2) return C_MEM_EN | C_B_LOAD;
            return 12'h000;
        end
        if (op == 4'h1) return C_ADD_EN | C_A_LOAD;
        if (op == 4'h2) return C_SUB | C_ADD_EN | C_A_LOAD;
        return 12'h000;
    endfunction

    task automatic rand_cycle(input logic [11:0] c, input logic pw, input logic [3:0] pa,
                              input logic [7:0] pd);
        @(negedge clk);
        u_if.ctrl = c;
        u_if.prog_we = pw;
        u_if.prog_addr = pa;
        u_if.prog_data = pd;
        #1;
        check("rnd_bus", 32'(u_if.bus_out), 32'(m_bus(c)));
        check("rnd_conflict", 32'(u_if.bus_conflict), 32'(n_en(c) > 1));
        check("rnd_opcode", 32'(u_if.opcode), 32'(m_ir[7:4]));
        m_edge(c, pw, pa, pd);
        @(posedge clk);
        #1;
        check("rnd_a", 32'(u_if.a_out), 32'(m_a));
        check("rnd_pc", 32'(u_if.pc_out), 32'(m_pc));
        check("rnd_carry", 32'(u_if.carry), 32'(m_c));
        check("rnd_zero", 32'(u_if.zero), 32'(m_z));
        check("rnd_halted", 32'(u_if.halted), 32'(m_h));
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        pw;
        logic [3:0]  pa;
        logic [7:0]  pd;
        logic [11:0] ctrl;
        logic [7:0]  ebus;
        logic        econf;
        logic [7:0]  ea;
        logic [3:0]  epc;
        logic        ec;
        logic        ez;
        logic        eh;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    initial begin
        int  t;
        bit  done;
        logic [11:0] c;

        u_if.ctrl = '0;
        u_if.prog_we = 1'b0;
        u_if.prog_addr = '0;
        u_if.prog_data = '0;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_reset();

        // Conflict, SUB to zero, ADD overflow, flag and halt corners.
        tbl[0]  = '{1'b1, 4'h0, 8'h55, 12'h000,                     8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 8'h00, C_MEM_EN | C_A_LOAD,         8'h55, 1'b0, 8'h55, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 8'h00, C_PC_INC,                    8'h00, 1'b0, 8'h55, 4'h1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 8'h00, C_PC_INC,                    8'h00, 1'b0, 8'h55, 4'h2, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'h0, 8'h00, C_PC_INC,                    8'h00, 1'b0, 8'h55, 4'h3, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 8'h00, C_PC_EN | C_A_EN | C_A_LOAD, 8'h03, 1'b1, 8'h03, 4'h3, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 8'h00, C_PC_INC,                    8'h00, 1'b0, 8'h03, 4'h4, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'h0, 8'h00, C_PC_INC,                    8'h00, 1'b0, 8'h03, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'h0, 8'h00, C_PC_EN | C_A_LOAD | C_B_LOAD, 8'h05, 1'b0, 8'h05, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 8'h00, C_SUB | C_ADD_EN | C_A_LOAD, 8'h00, 1'b0, 8'h00, 4'h5, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'h0, 8'hF0, 12'h000,                     8'h00, 1'b0, 8'h00, 4'h5, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 8'h00, C_MEM_EN | C_A_LOAD,         8'hF0, 1'b0, 8'hF0, 4'h5, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'h0, 8'h20, 12'h000,                     8'h00, 1'b0, 8'hF0, 4'h5, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'h0, 8'h00, C_MEM_EN | C_B_LOAD,         8'h20, 1'b0, 8'hF0, 4'h5, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'h0, 8'h00, C_ADD_EN | C_A_LOAD,         8'h10, 1'b0, 8'h10, 4'h5, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 8'h00, C_SUB | C_ADD_EN | C_A_LOAD, 8'hF0, 1'b0, 8'hF0, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'h0, 8'h00, C_A_EN | C_ADD_EN | C_B_LOAD, 8'hF0, 1'b1, 8'hF0, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'h0, 8'h00, C_ADD_EN | C_A_LOAD,         8'hE0, 1'b0, 8'hE0, 4'h5, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'h0, 8'h00, C_MEM_EN | C_IR_LOAD | C_PC_INC, 8'h20, 1'b0, 8'hE0, 4'h6, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 4'h0, 8'h00, C_IR_EN | C_ADD_EN | C_A_LOAD, 8'h00, 1'b1, 8'h00, 4'h6, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 4'h0, 8'h00, C_HLT | C_A_EN | C_B_LOAD,   8'h00, 1'b0, 8'h00, 4'h6, 1'b1, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 4'h0, 8'h00, C_PC_INC | C_MEM_EN | C_A_LOAD, 8'h20, 1'b0, 8'h00, 4'h6, 1'b1, 1'b0, 1'b1};

        // ---- Reset state ----
        apply_reset(1'b0);
        #1;
        check("reset_a", 32'(u_if.a_out), 32'h0);
        check("reset_pc", 32'(u_if.pc_out), 32'h0);
        check("reset_carry", 32'(u_if.carry), 32'h0);
        check("reset_zero", 32'(u_if.zero), 32'h0);
        check("reset_halted", 32'(u_if.halted), 32'h0);
        check("reset_opcode", 32'(u_if.opcode), 32'h0);
        check("reset_bus", 32'(u_if.bus_out), 32'h0);

        // ---- Table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            u_if.ctrl = tbl[i].ctrl;
            u_if.prog_we = tbl[i].pw;
            u_if.prog_addr = tbl[i].pa;
            u_if.prog_data = tbl[i].pd;
            #1;
            check($sformatf("vec%0d_bus", i), 32'(u_if.bus_out), 32'(tbl[i].ebus));
            check($sformatf("vec%0d_conflict", i), 32'(u_if.bus_conflict), 32'(tbl[i].econf));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_a", i), 32'(u_if.a_out), 32'(tbl[i].ea));
            check($sformatf("vec%0d_pc", i), 32'(u_if.pc_out), 32'(tbl[i].epc));
            check($sformatf("vec%0d_carry", i), 32'(u_if.carry), 32'(tbl[i].ec));
            check($sformatf("vec%0d_zero", i), 32'(u_if.zero), 32'(tbl[i].ez));
            check($sformatf("vec%0d_halted", i), 32'(u_if.halted), 32'(tbl[i].eh));
        end
        @(negedge clk);
        u_if.prog_we = 1'b0;

        // ---- PC wrap ----
        apply_reset(1'b0);
        #1;
        check("wrap_pc_start", 32'(u_if.pc_out), 32'h0);
        for (int i = 0; i < 16; i++) begin
            tick(C_PC_INC);
            check($sformatf("wrap_pc%0d", i + 1), 32'(u_if.pc_out), 32'((i + 1) % 16));
        end

        // ---- Program run (RAM loaded while in reset) ----
        apply_reset(1'b1);
        t = 1;
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            u_if.ctrl = seq_ctrl(t, u_if.opcode);
            @(posedge clk);
            #1;
            t = (t == 6) ? 1 : t + 1;
            if (u_if.halted) done = 1'b1;
        end
        check("prog_halted", 32'(u_if.halted), 32'h1);
        check("prog_a", 32'(u_if.a_out), 32'h26);
        check("prog_carry", 32'(u_if.carry), 32'h1);
        check("prog_zero", 32'(u_if.zero), 32'h0);
        check("prog_pc", 32'(u_if.pc_out), 32'h4);
        check("prog_opcode", 32'(u_if.opcode), 32'hF);
        for (int i = 0; i < 20; i++) begin
            tick(12'($urandom));
            check($sformatf("frozen_a%0d", i), 32'(u_if.a_out), 32'h26);
            check($sformatf("frozen_pc%0d", i), 32'(u_if.pc_out), 32'h4);
        end

        // ---- Asynchronous reset during stage 4 of LDA ----
        apply_reset(1'b0);
        tick(C_MEM_EN | C_A_LOAD | C_B_LOAD);   // A = B = RAM[0] = 09
        tick(C_ADD_EN | C_A_LOAD);              // A = 12
        for (int s = 1; s <= 3; s++) tick(seq_ctrl(s, u_if.opcode));
        @(negedge clk);
        u_if.ctrl = seq_ctrl(4, u_if.opcode);
        #1;
        check("midrst_pre_bus", 32'(u_if.bus_out), 32'h09);
        check("midrst_pre_a", 32'(u_if.a_out), 32'h12);
        check("midrst_pre_pc", 32'(u_if.pc_out), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_a", 32'(u_if.a_out), 32'h0);
        check("midrst_pc", 32'(u_if.pc_out), 32'h0);
        check("midrst_halted", 32'(u_if.halted), 32'h0);
        check("midrst_carry", 32'(u_if.carry), 32'h0);
        check("midrst_zero", 32'(u_if.zero), 32'h0);
        check("midrst_bus", 32'(u_if.bus_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 9; i++) tick(C_PC_INC);
        tick(C_PC_EN | C_MAR_LOAD);
        @(negedge clk);
        u_if.ctrl = C_MEM_EN;
        #1;
        check("midrst_ram9", 32'(u_if.bus_out), 32'h1C);

        // ---- Randomized phase against the model ----
        apply_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            rand_cycle(12'h000, 1'b1, 4'(i), 8'($urandom));
        end
        for (int i = 0; i < 500; i++) begin
            c = 12'($urandom) & 12'h7FF;
            if ($urandom_range(0, 63) == 0) c[HLT] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                rand_cycle(c, 1'b1, 4'($urandom), 8'($urandom));
            end else begin
                rand_cycle(c, 1'b0, 4'h0, 8'h00);
            end
            if (m_h && $urandom_range(0, 7) == 0) apply_reset(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
